// File: rtl/stream_fifo.sv
// stream_fifo: ap_fifo channel between two streaming layers.
// The upstream layer writes through din/full_n/write and the downstream
// layer reads through dout/empty_n/read. The head word falls through to
// if_dout. Occupancy, and the full/empty flags decoded from it, are registered.
// Optional statistics (high-water mark, sticky overflow/underflow) are built
// only when STREAM_FIFO_STATS_EN is defined. Otherwise those outputs are
// tied to 0 and stats_clr is ignored.
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [WIDTH-1:0] if_din,
  output logic             if_full_n,
  input  logic             if_write,
  output logic [WIDTH-1:0] if_dout,
  output logic             if_empty_n,
  input  logic             if_read,
  output logic [CNT_W-1:0] count,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] max_count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wacc, racc;

  // Flags come from registered occupancy only. This keeps request inputs
  // out of every combinational path to the outputs.
  assign if_full_n  = (count_q != CNT_W'(DEPTH));
  assign if_empty_n = (count_q != '0);
  assign count      = count_q;

  assign wacc = if_write && if_full_n;
  assign racc = if_read && if_empty_n;

  // First-word fall-through head, forced to 0 while the queue is empty.
  assign if_dout = if_empty_n ? mem[rd_ptr_q] : '0;

  // Next-state for the pointers (wrapping at DEPTH-1, so the depth need not
  // be a power of two) and for the occupancy counter.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wacc) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (racc) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (wacc && !racc) begin
      count_d = count_q + CNT_W'(1);
    end else if (racc && !wacc) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Control state registers. Reset discards everything in flight.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written only on an accepted write.
  // NOTE: the array has no reset. count gates every read, so stale contents are never observed.
  always_ff @(posedge ap_clk) begin
    if (wacc) begin
      mem[wr_ptr_q] <= if_din;
    end
  end

`ifdef STREAM_FIFO_STATS_EN
  logic [CNT_W-1:0] max_count_q;
  logic             overflow_q;
  logic             underflow_q;

  // High-water mark and sticky error flags. A clear beats a same-cycle set.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      max_count_q <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (stats_clr) begin
      max_count_q <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (count_q > max_count_q) begin
        max_count_q <= count_q;
      end
      if (if_write && !if_full_n) begin
        overflow_q <= 1'b1;
      end
      if (if_read && !if_empty_n) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign max_count = max_count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_stats_clr;

  assign unused_stats_clr = stats_clr;
  assign max_count        = '0;
  assign overflow         = 1'b0;
  assign underflow        = 1'b0;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Directed testbench for stream_fifo with WIDTH=8 and DEPTH=4.
// Inputs are driven 1 time unit after each rising edge. Outputs are
// checked at that same point, so each check sees the state left by that edge.
module tb_stream_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef STREAM_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             ap_clk = 1'b0;
  logic             ap_rst_n;
  logic [WIDTH-1:0] if_din;
  logic             if_full_n;
  logic             if_write;
  logic [WIDTH-1:0] if_dout;
  logic             if_empty_n;
  logic             if_read;
  logic [CNT_W-1:0] count;
  logic             stats_clr;
  logic [CNT_W-1:0] max_count;
  logic             overflow;
  logic             underflow;

  int n_cmp = 0;
  int n_err = 0;

  stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .if_din     (if_din),
    .if_full_n  (if_full_n),
    .if_write   (if_write),
    .if_dout    (if_dout),
    .if_empty_n (if_empty_n),
    .if_read    (if_read),
    .count      (count),
    .stats_clr  (stats_clr),
    .max_count  (max_count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".full_n"},  32'(if_full_n),  32'd1);
    check({tag, ".empty_n"}, 32'(if_empty_n), 32'd0);
    check({tag, ".dout"},    32'(if_dout),    32'h00);
    check({tag, ".count"},   32'(count),      32'd0);
  endtask

  logic [7:0] fill_vec [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] full_vec [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};

  initial begin
    ap_rst_n  = 1'b0;
    if_din    = '0;
    if_write  = 1'b0;
    if_read   = 1'b0;
    stats_clr = 1'b0;

    // Reset, then 10 idle cycles.
    step();
    step();
    check_idle("reset");
    check("reset.max_count", 32'(max_count), 32'd0);
    check("reset.overflow",  32'(overflow),  32'd0);
    check("reset.underflow", 32'(underflow), 32'd0);
    ap_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_idle("idle");
    end

    // Fill with four words on consecutive cycles.
    if_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_din = fill_vec[i];
      step();
      check("fill.count", 32'(count),      32'(i + 1));
      check("fill.dout",  32'(if_dout),    32'h11);
      check("fill.empty", 32'(if_empty_n), 32'd1);
      check("fill.full",  32'(if_full_n),  (i == 3) ? 32'd0 : 32'd1);
    end
    if_write = 1'b0;

    // Drain the four words in order.
    if_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain.dout", 32'(if_dout), 32'(fill_vec[i]));
      step();
      check("drain.full_n", 32'(if_full_n), 32'd1);
    end
    if_read = 1'b0;
    check_idle("drained");
    check("drained.max_count", 32'(max_count), STATS ? 32'd4 : 32'd0);
    check("drained.overflow",  32'(overflow),  32'd0);
    check("drained.underflow", 32'(underflow), 32'd0);

    // Wrap-around streaming with write and read held high.
    if_write = 1'b1;
    if_read  = 1'b1;
    if_din   = 8'h00;
    step();
    check("wrap.first.count", 32'(count),   32'd1);
    check("wrap.first.dout",  32'(if_dout), 32'h00);
    for (int i = 1; i < 16; i++) begin
      check("wrap.dout", 32'(if_dout), 32'(i - 1));
      if_din = 8'(i);
      step();
      check("wrap.count", 32'(count), 32'd1);
    end
    check("wrap.last.dout", 32'(if_dout), 32'h0F);
    if_write = 1'b0;
    step();
    if_read = 1'b0;
    check_idle("wrap.end");
    check("wrap.underflow", 32'(underflow), STATS ? 32'd1 : 32'd0);
    check("wrap.max_count", 32'(max_count), STATS ? 32'd4 : 32'd0);

    // Clear statistics.
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    check("clr.max_count", 32'(max_count), 32'd0);
    check("clr.overflow",  32'(overflow),  32'd0);
    check("clr.underflow", 32'(underflow), 32'd0);

    // Full, then a simultaneous write and read: pop the head, drop the write.
    if_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_din = full_vec[i];
      step();
    end
    check("full.count",  32'(count),     32'd4);
    check("full.full_n", 32'(if_full_n), 32'd0);
    if_din  = 8'hAA;
    if_read = 1'b1;
    step();
    if_write = 1'b0;
    check("fullwr.count",     32'(count),     32'd3);
    check("fullwr.dout",      32'(if_dout),   32'hA2);
    check("fullwr.full_n",    32'(if_full_n), 32'd1);
    check("fullwr.overflow",  32'(overflow),  STATS ? 32'd1 : 32'd0);
    check("fullwr.max_count", 32'(max_count), STATS ? 32'd4 : 32'd0);
    for (int i = 1; i < 4; i++) begin
      check("fulldrain.dout", 32'(if_dout), 32'(full_vec[i]));
      step();
    end
    if_read = 1'b0;
    check_idle("fulldrain.end");

    // Empty, then a simultaneous write and read: only the write is taken.
    if_din   = 8'h5A;
    if_write = 1'b1;
    if_read  = 1'b1;
    step();
    if_read = 1'b0;
    check("emptywr.count",     32'(count),      32'd1);
    check("emptywr.dout",      32'(if_dout),    32'h5A);
    check("emptywr.empty_n",   32'(if_empty_n), 32'd1);
    check("emptywr.underflow", 32'(underflow),  STATS ? 32'd1 : 32'd0);

    // Build up to count=3, then apply an async reset between edges.
    if_din = 8'h61;
    step();
    if_din = 8'h62;
    step();
    if_write = 1'b0;
    check("prerst.count", 32'(count),   32'd3);
    check("prerst.dout",  32'(if_dout), 32'h5A);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check_idle("asyncrst");
    check("asyncrst.max_count", 32'(max_count), 32'd0);
    check("asyncrst.overflow",  32'(overflow),  32'd0);
    check("asyncrst.underflow", 32'(underflow), 32'd0);
    #1;
    ap_rst_n = 1'b1;
    step();
    check_idle("postrst");

    // The first write after reset returns fresh data with no stale words.
    if_din   = 8'h77;
    if_write = 1'b1;
    step();
    if_write = 1'b0;
    check("postrst.dout",  32'(if_dout), 32'h77);
    check("postrst.count", 32'(count),   32'd1);
    if_read = 1'b1;
    step();
    if_read = 1'b0;
    check_idle("postrst.end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
